// File: rtl/unified_mem.sv
// Line-granular unified main memory with fixed multi-cycle access latency and one-cycle rdy pulse.
// Optional protocol checking is built when UNIFIED_MEM_CHK_EN is defined; otherwise err is tied low.
module unified_mem #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [63:0]       wdata,
  output logic [63:0]       rd_data,
  output logic              rdy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              op_we_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rd_data_q;
  logic              rdy_q;

  logic [63:0] mem [2**ADDR_W];

  logic access;
  assign access = (state_q == BUSY) && (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      op_we_q   <= 1'b0;
      wdata_q   <= 64'd0;
      rd_data_q <= 64'd0;
      rdy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (we || re) begin
            addr_q  <= addr;
            op_we_q <= we;
            wdata_q <= wdata;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd0) begin
            if (!op_we_q) rd_data_q <= mem[addr_q];
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        // DONE ignores requests so a request still held during rdy is not taken twice.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array has no reset; a reset mid-access returns to IDLE before this enable can fire.
  always_ff @(posedge clk) begin
    if (access && op_we_q) mem[addr_q] <= wdata_q;
  end

  assign rd_data = rd_data_q;
  assign rdy     = rdy_q;

`ifdef UNIFIED_MEM_CHK_EN
  logic err_q;
  logic req_re_q;
  logic held;
  logic changed;

  assign held    = re || we;
  assign changed = (addr != addr_q) || (re != req_re_q) || (we != op_we_q) ||
                   (op_we_q && (wdata != wdata_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      req_re_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && held) req_re_q <= re;
      if (((state_q == IDLE) && re && we) || ((state_q == BUSY) && held && changed))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: vector table, hand-written corner sequences and
// randomized traffic against an associative-array memory model.
module tb_unified_mem;

  localparam int LAT = 4;
  localparam int AW  = 14;

`ifdef UNIFIED_MEM_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          re;
  logic          we;
  logic [63:0]   wdata;
  logic [63:0]   rd_data;
  logic          rdy;
  logic          err;

  unified_mem #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .re     (re),
    .we     (we),
    .wdata  (wdata),
    .rd_data(rd_data),
    .rdy    (rdy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [int];
  logic [63:0] last_rd;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [63:0]   d;
    logic [63:0]   exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Counts falling edges until rdy is seen; 0 means the bound expired.
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (rdy) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_rdy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
  endtask

  // Issue one request at a falling edge in IDLE, drop it on rdy, end at the next falling edge.
  task automatic req(input logic w, input logic r, input logic [AW-1:0] a,
                     input logic [63:0] d, input string name, output logic [63:0] rd);
    int lat;
    we = w; re = r; addr = a; wdata = d;
    wait_rdy(lat);
    chk({name, " latency"}, 64'(lat), 64'(LAT + 1));
    rd = rd_data;
    if (w) begin
      model[int'(a)] = d;
      chk({name, " rd_data held"}, rd_data, last_rd);
    end else if (model.exists(int'(a))) begin
      chk({name, " read vs model"}, rd_data, model[int'(a)]);
      last_rd = model[int'(a)];
    end
    we = 1'b0; re = 1'b0;
    @(negedge clk);
    chk({name, " rdy width"}, 64'(rdy), 64'd0);
  endtask

  initial begin
    logic [63:0]   rd;
    int            lat;
    int            cnt;
    logic [AW-1:0] ra;
    logic          rw;

    tbl[0] = '{1'b1, 14'h0010, 64'h0123_4567_89AB_CDEF, 64'd0};
    tbl[1] = '{1'b0, 14'h0010, 64'd0, 64'h0123_4567_89AB_CDEF};
    tbl[2] = '{1'b1, 14'h3FFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    tbl[3] = '{1'b1, 14'h0000, 64'h0000_0000_0000_0000, 64'd0};
    tbl[4] = '{1'b0, 14'h3FFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{1'b0, 14'h0000, 64'd0, 64'h0000_0000_0000_0000};
    tbl[6] = '{1'b1, 14'h0010, 64'hDEAD_BEEF_CAFE_F00D, 64'd0};
    tbl[7] = '{1'b0, 14'h0010, 64'd0, 64'hDEAD_BEEF_CAFE_F00D};

    re = 1'b0; we = 1'b0; addr = '0; wdata = 64'd0;
    last_rd = 64'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset rdy", 64'(rdy), 64'd0);
    chk("reset rd_data", rd_data, 64'd0);
    chk("reset err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      req(tbl[i].w, !tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("tbl%0d", i), rd);
      if (!tbl[i].w) chk($sformatf("tbl%0d expected", i), rd, tbl[i].exp);
    end

    // Held write through the rdy cycle must complete exactly once.
    we = 1'b1; re = 1'b0; addr = 14'h0050; wdata = 64'h5555_AAAA_5555_AAAA;
    wait_rdy(lat);
    chk("dedup latency", 64'(lat), 64'(LAT + 1));
    @(negedge clk);
    we = 1'b0;
    model[32'h50] = 64'h5555_AAAA_5555_AAAA;
    count_rdy(LAT + 3, cnt);
    chk("dedup extra rdy", 64'(cnt), 64'd0);
    chk("dedup err", 64'(err), 64'd0);
    req(1'b0, 1'b1, 14'h0050, 64'd0, "dedup readback", rd);

    // Write-back then fill presented in the cycle right after rdy.
    req(1'b1, 1'b0, 14'h0021, 64'h2121_2121_0000_0021, "prefill", rd);
    we = 1'b1; re = 1'b0; addr = 14'h0020; wdata = 64'h2020_2020_0000_0020;
    wait_rdy(lat);
    chk("wb latency", 64'(lat), 64'(LAT + 1));
    model[32'h20] = 64'h2020_2020_0000_0020;
    we = 1'b0; re = 1'b1; addr = 14'h0021;
    wait_rdy(lat);
    chk("fill latency", 64'(lat), 64'(LAT + 2));
    chk("fill data", rd_data, 64'h2121_2121_0000_0021);
    last_rd = 64'h2121_2121_0000_0021;
    re = 1'b0;
    @(negedge clk);
    req(1'b0, 1'b1, 14'h0020, 64'd0, "wb readback", rd);
    chk("wb readback value", rd, 64'h2020_2020_0000_0020);

    // Reset in the second BUSY cycle drops the pending write.
    req(1'b1, 1'b0, 14'h0030, 64'h1, "pre write", rd);
    req(1'b0, 1'b1, 14'h0030, 64'd0, "pre read", rd);
    we = 1'b1; re = 1'b0; addr = 14'h0030; wdata = 64'hFFFF;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst rdy", 64'(rdy), 64'd0);
    chk("midrst rd_data", rd_data, 64'd0);
    chk("midrst err", 64'(err), 64'd0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 64'd0;
    count_rdy(LAT + 3, cnt);
    chk("midrst no rdy", 64'(cnt), 64'd0);
    req(1'b0, 1'b1, 14'h0030, 64'd0, "midrst readback", rd);
    chk("midrst array kept", rd, 64'h1);

    // re and we together: the write wins.
    req(1'b1, 1'b1, 14'h0040, 64'hA5, "collision", rd);
    chk("collision err", 64'(err), 64'(CHK));
    req(1'b0, 1'b1, 14'h0040, 64'd0, "collision readback", rd);
    chk("collision value", rd, 64'hA5);

    for (int i = 0; i < 40; i++) begin
      ra = 14'(200 + $urandom_range(0, 7));
      rw = !model.exists(int'(ra)) || ($urandom_range(0, 1) == 1);
      req(rw, !rw, ra, {$urandom, $urandom}, $sformatf("rnd%0d", i), rd);
    end
    chk("final err", 64'(err), 64'(CHK));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
